// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX frame receiver, the TX path and the APB
// register decode: FSM state encoding, error-flag bit positions and the
// data-width rule.
package uart_pkg;

    localparam int DATA_BITS_MAX = 8;

    // Bit positions inside the 4-bit error vector {break, overrun, frame, parity}
    localparam int ERR_PARITY  = 0;
    localparam int ERR_FRAME   = 1;
    localparam int ERR_OVERRUN = 2;
    localparam int ERR_BREAK   = 3;
    localparam int ERR_W       = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } rx_state_e;

    // Frame widths outside 5..8 fall back to a full byte.
    function automatic logic [3:0] eff_data_bits(input logic [3:0] n);
        if (n >= 4'd5 && n <= 4'd8) begin
            return n;
        end
        return 4'(DATA_BITS_MAX);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous, idle-high serial input.
// Every stage resets to 1 so that leaving reset never looks like a start edge.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the synchroniser chain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: oversampled start detection, mid-bit sampling of data,
// optional parity and one or two stop bits, with a registered valid/ready
// output and sticky error flags.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | line idle, waiting for a falling edge on the synchronised input
// START  | confirming the start bit at its mid sample (high = glitch)
// DATA   | sampling data bits LSB first, one per bit period
// PARITY | sampling and checking the parity bit
// STOP1  | sampling the first stop bit; break detection happens here
// STOP2  | sampling the optional second stop bit
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       os_tick,
    input  logic       rx_en,
    input  logic [3:0] number_data_receive,
    input  logic       parity_en,
    input  logic       parity_bit_mode,
    input  logic       stop_bit_twice,
    input  logic       UART_RXD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic [3:0] rx_errors,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    // Down-counter reload values: half a bit to reach the start-bit centre,
    // then a full bit period between successive centres.
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [3:0]       nbits_q, nbits_d;
    logic             par_en_q, par_en_d;
    logic             par_even_q, par_even_d;
    logic             stop2_q, stop2_d;
    logic             zero_q, zero_d;

    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [3:0]       err_q, err_d;

    logic             rxd_s;
    logic             rxd_prev_q;
    logic             start_edge;
    logic             sample;
    logic             last_bit;
    logic             parity_ok;
    logic             deliver;
    logic             set_par;
    logic             set_frm;
    logic             set_brk;
    logic             set_ovr;
    logic             handshake;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (PCLK),
        .rst_i (PRESET),
        .d_i   (UART_RXD),
        .q_o   (rxd_s)
    );

    assign start_edge = rxd_prev_q & ~rxd_s;
    assign sample     = os_tick & (cnt_q == '0) & (state_q != IDLE);
    assign last_bit   = ({1'b0, bit_idx_q} == (nbits_q - 4'd1));
    assign parity_ok  = (((^shift_q) ^ rxd_s) == ~par_even_q);
    assign handshake  = rx_valid_q & rx_ready;

    // Frame sequencing: sample timing, bit assembly and error detection
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_even_d = par_even_q;
        stop2_d    = stop2_q;
        zero_d     = zero_q;
        deliver    = 1'b0;
        set_par    = 1'b0;
        set_frm    = 1'b0;
        set_brk    = 1'b0;

        if (state_q != IDLE && os_tick) begin
            cnt_d = (cnt_q == '0) ? CNT_LAST : cnt_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rx_en && start_edge) begin
                    state_d    = START;
                    cnt_d      = CNT_MID;
                    bit_idx_d  = '0;
                    shift_d    = '0;
                    zero_d     = 1'b1;
                    nbits_d    = eff_data_bits(number_data_receive);
                    par_en_d   = parity_en;
                    par_even_d = parity_bit_mode;
                    stop2_d    = stop_bit_twice;
                end
            end
            START: begin
                if (sample) begin
                    state_d = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d[bit_idx_q] = rxd_s;
                    zero_d             = zero_q & ~rxd_s;
                    if (last_bit) begin
                        state_d = par_en_q ? PARITY : STOP1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    set_par = ~parity_ok;
                    zero_d  = zero_q & ~rxd_s;
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (sample) begin
                    if (zero_q && !rxd_s) begin
                        // Whole frame held low: report a break, drop the byte.
                        set_brk = 1'b1;
                        set_frm = 1'b1;
                        state_d = IDLE;
                    end else begin
                        set_frm = ~rxd_s;
                        if (stop2_q) begin
                            state_d = STOP2;
                        end else begin
                            deliver = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            STOP2: begin
                if (sample) begin
                    set_frm = ~rxd_s;
                    deliver = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Disabling the receiver abandons the frame without side effects.
        if (!rx_en) begin
            state_d = IDLE;
            deliver = 1'b0;
            set_par = 1'b0;
            set_frm = 1'b0;
            set_brk = 1'b0;
        end
    end

    // Output holding register, overrun detection and sticky error flags
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        set_ovr    = 1'b0;

        if (handshake) begin
            rx_valid_d = 1'b0;
        end
        if (deliver) begin
            if (rx_valid_q && !rx_ready) begin
                set_ovr = 1'b1;
            end else begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end
        end

        err_d = err_q;
        err_d[ERR_PARITY]  = err_q[ERR_PARITY]  | set_par;
        err_d[ERR_FRAME]   = err_q[ERR_FRAME]   | set_frm;
        err_d[ERR_OVERRUN] = err_q[ERR_OVERRUN] | set_ovr;
        err_d[ERR_BREAK]   = err_q[ERR_BREAK]   | set_brk;
        if (err_clr) begin
            err_d = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            nbits_q    <= 4'(DATA_BITS_MAX);
            par_en_q   <= 1'b0;
            par_even_q <= 1'b0;
            stop2_q    <= 1'b0;
            zero_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            err_q      <= '0;
            rxd_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_even_q <= par_even_d;
            stop2_q    <= stop2_d;
            zero_q     <= zero_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            err_q      <= err_d;
            rxd_prev_q <= rxd_s;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_errors = err_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed frames followed by random
// frames, all compared against a frame-level reference model.
module tb_uart_rx_frame;

    localparam int OS       = 16;
    localparam int TICK_DIV = 5;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       os_tick = 1'b0;
    logic       rx_en = 1'b1;
    logic [3:0] number_data_receive = 4'd8;
    logic       parity_en = 1'b0;
    logic       parity_bit_mode = 1'b0;
    logic       stop_bit_twice = 1'b0;
    logic       UART_RXD = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [3:0] rx_errors;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;
    int tick_div_cnt = 0;

    // Reference model state: what the consumer should see
    bit         exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    logic [3:0] exp_err   = 4'h0;

    uart_rx_frame #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .PCLK                (PCLK),
        .PRESET              (PRESET),
        .os_tick             (os_tick),
        .rx_en               (rx_en),
        .number_data_receive (number_data_receive),
        .parity_en           (parity_en),
        .parity_bit_mode     (parity_bit_mode),
        .stop_bit_twice      (stop_bit_twice),
        .UART_RXD            (UART_RXD),
        .rx_data             (rx_data),
        .rx_valid            (rx_valid),
        .rx_ready            (rx_ready),
        .err_clr             (err_clr),
        .rx_errors           (rx_errors),
        .rx_busy             (rx_busy)
    );

    always #5 PCLK = ~PCLK;

    // Oversample tick: one PCLK pulse every TICK_DIV cycles, changed on negedge
    always @(negedge PCLK) begin
        tick_div_cnt = (tick_div_cnt == TICK_DIV - 1) ? 0 : tick_div_cnt + 1;
        os_tick = (tick_div_cnt == 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_bits(input logic [3:0] n);
        return (n >= 5 && n <= 8) ? int'(n) : 8;
    endfunction

    function automatic logic [7:0] mask_bits(input logic [7:0] d, input int n);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < n; i++) m[i] = d[i];
        return m;
    endfunction

    // Frame-level reference: decide flags and delivery from the bit values sent
    task automatic model_frame(input int n, input logic [7:0] d, input bit pen, input bit even,
                               input bit pbit, input bit s1, input bit two_stop, input bit s2);
        logic [7:0] m;
        bit good_p;
        m = mask_bits(d, n);
        if (m == 8'h00 && (!pen || !pbit) && !s1) begin
            exp_err = exp_err | 4'b1010;
            return;
        end
        good_p = even ? ^m : ~^m;
        if (pen && pbit != good_p) exp_err[0] = 1'b1;
        if (!s1 || (two_stop && !s2)) exp_err[1] = 1'b1;
        if (exp_valid) begin
            exp_err[2] = 1'b1;
        end else begin
            exp_valid = 1'b1;
            exp_data  = m;
        end
    endtask

    task automatic wait_tick();
        @(posedge PCLK);
        while (!os_tick) @(posedge PCLK);
    endtask

    task automatic drive_level(input logic v, input int ticks);
        #1 UART_RXD = v;
        repeat (ticks) wait_tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pbit, input bit s1, input bit s2,
                              input int gap_bits);
        int n;
        n = eff_bits(number_data_receive);
        drive_level(1'b0, OS);
        for (int i = 0; i < n; i++) drive_level(d[i], OS);
        if (parity_en) drive_level(pbit, OS);
        drive_level(s1, OS);
        if (stop_bit_twice) drive_level(s2, OS);
        if (gap_bits > 0) drive_level(1'b1, gap_bits * OS);
        model_frame(n, d, parity_en, parity_bit_mode, pbit, s1, stop_bit_twice, s2);
    endtask

    task automatic consume();
        @(negedge PCLK) rx_ready = 1'b1;
        @(negedge PCLK) rx_ready = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic clear_errors();
        @(negedge PCLK) err_clr = 1'b1;
        @(negedge PCLK) err_clr = 1'b0;
        exp_err = 4'h0;
    endtask

    task automatic set_cfg(input logic [3:0] n, input bit pen, input bit even, input bit two);
        @(negedge PCLK);
        number_data_receive = n;
        parity_en           = pen;
        parity_bit_mode     = even;
        stop_bit_twice      = two;
    endtask

    task automatic check_frame(input string tag);
        @(negedge PCLK);
        check({tag, ".busy"}, rx_busy, 0);
        check({tag, ".valid"}, rx_valid, exp_valid);
        if (exp_valid) check({tag, ".data"}, rx_data, exp_data);
        check({tag, ".err"}, rx_errors, exp_err);
    endtask

    function automatic bit good_parity(input logic [7:0] d, input bit even);
        return even ? ^d : ~^d;
    endfunction

    initial begin
        logic [7:0] d;
        bit pb;
        bit s1;
        bit s2;
        int n;

        repeat (3) @(negedge PCLK);
        check("rst.data", rx_data, 0);
        check("rst.valid", rx_valid, 0);
        check("rst.err", rx_errors, 0);
        check("rst.busy", rx_busy, 0);
        PRESET = 1'b0;
        repeat (4) wait_tick();

        // 8 data bits, even parity, two stop bits
        set_cfg(4'd8, 1'b1, 1'b1, 1'b1);
        send_frame(8'h6D, 1'b1, 1'b1, 1'b1, 2);
        check_frame("even_6d");
        check("even_6d.const_data", rx_data, 8'h6D);
        check("even_6d.const_err", rx_errors, 4'b0000);
        consume();

        send_frame(8'h79, 1'b0, 1'b1, 1'b1, 2);
        check_frame("parerr_79");
        check("parerr_79.const_err", rx_errors, 4'b0001);
        consume();
        clear_errors();

        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        send_frame(8'h41, 1'b0, 1'b0, 1'b1, 2);
        check_frame("frmerr_41");
        check("frmerr_41.const_err", rx_errors, 4'b0010);
        consume();
        clear_errors();

        send_frame(8'h48, 1'b0, 1'b1, 1'b1, 0);
        send_frame(8'h45, 1'b0, 1'b1, 1'b1, 2);
        check_frame("overrun");
        check("overrun.const_data", rx_data, 8'h48);
        check("overrun.const_err", rx_errors, 4'b0100);
        clear_errors();
        @(negedge PCLK);
        check("overrun.cleared", rx_errors, 4'b0000);
        consume();
        @(negedge PCLK);
        check("consume.valid", rx_valid, 0);

        // Short low glitch on an idle line
        drive_level(1'b0, 4);
        drive_level(1'b1, 0);
        @(negedge PCLK);
        check("glitch.busy_hi", rx_busy, 1);
        repeat (4) wait_tick();
        repeat (2) @(negedge PCLK);
        check("glitch.busy_lo", rx_busy, 0);
        check("glitch.valid", rx_valid, 0);
        check("glitch.err", rx_errors, 0);

        // Receiver disabled mid-frame
        drive_level(1'b0, OS);
        drive_level(1'b1, OS);
        drive_level(1'b1, OS / 2);
        @(negedge PCLK) rx_en = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        check("abort.busy", rx_busy, 0);
        drive_level(1'b1, 8 * OS);
        @(negedge PCLK) rx_en = 1'b1;
        repeat (OS) wait_tick();
        check_frame("abort");

        // Break: 12 bit times low
        drive_level(1'b0, 12 * OS);
        drive_level(1'b1, 2 * OS);
        model_frame(8, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("break");
        check("break.const_err", rx_errors, 4'b1010);

        // 5-bit frame, left pending (with break flags still set) for the reset test
        set_cfg(4'd5, 1'b0, 1'b0, 1'b0);
        send_frame(8'h15, 1'b0, 1'b1, 1'b1, 2);
        check_frame("five_15");
        check("five_15.const_data", rx_data, 8'h15);

        // Asynchronous reset in the middle of the data bits
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        drive_level(1'b0, OS);
        drive_level(1'b1, OS);
        drive_level(1'b1, OS);
        drive_level(1'b0, OS / 2);
        @(negedge PCLK);
        check("mid_rst.busy_before", rx_busy, 1);
        #2 PRESET = 1'b1;
        #1;
        check("mid_rst.data", rx_data, 0);
        check("mid_rst.valid", rx_valid, 0);
        check("mid_rst.err", rx_errors, 0);
        check("mid_rst.busy", rx_busy, 0);
        UART_RXD = 1'b1;
        @(negedge PCLK) PRESET = 1'b0;
        exp_valid = 1'b0;
        exp_err   = 4'h0;
        repeat (2 * OS) wait_tick();
        send_frame(8'h4F, 1'b0, 1'b1, 1'b1, 2);
        check_frame("after_rst_4f");
        check("after_rst_4f.const_data", rx_data, 8'h4F);
        consume();

        // Random frames
        for (int k = 0; k < 16; k++) begin
            set_cfg(4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
                    1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            n  = eff_bits(number_data_receive);
            d  = 8'($urandom);
            if ($urandom_range(7, 0) == 0) d = 8'h00;
            pb = good_parity(mask_bits(d, n), parity_bit_mode);
            if ($urandom_range(3, 0) == 0) pb = ~pb;
            s1 = ($urandom_range(5, 0) != 0);
            s2 = ($urandom_range(5, 0) != 0);
            send_frame(d, pb, s1, s2, 1);
            check_frame($sformatf("rnd%0d", k));
            if ($urandom_range(1, 0) == 1) consume();
            if ($urandom_range(2, 0) == 0) clear_errors();
        end
        @(negedge PCLK);
        check("final.valid", rx_valid, exp_valid);
        check("final.err", rx_errors, exp_err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
